// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch path, the data path, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch side
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;

  // Data side
  logic                if_unused_pad;
  logic                d_req_valid;
  logic                d_req_we;
  logic [ADDR_W-1:0]   d_req_addr;
  logic [DATA_W-1:0]   d_req_wdata;
  logic [DATA_W/8-1:0] d_req_wstrb;
  logic                d_req_ready;
  logic                d_resp_valid;
  logic [DATA_W-1:0]   d_resp_data;

  // Memory port
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wstrb;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction in flight; data has priority, bounded by a starvation counter that
// eventually forces a fetch grant. A flush cancels delivery of an in-flight fetch response.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  mem_arbiter_if.slave   bus,
  output logic           busy,
  output logic           owner
);
  localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);
  localparam logic            OwnIf  = 1'b0;
  localparam logic            OwnD   = 1'b1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic            drop_q;

  logic starve_hit;
  logic d_grant;
  logic if_grant;

  // IDLE arbitration: data wins unless fetch has waited out STARVE_MAX data grants.
  // Nothing is accepted while reset is asserted, since the reset would discard it.
  always_comb begin
    starve_hit = bus.if_req_valid && bus.d_req_valid && (starve_q == CntMax);
    d_grant    = rst && (state_q == StIdle) && bus.d_req_valid && !starve_hit;
    if_grant   = rst && (state_q == StIdle) && bus.if_req_valid && !flush &&
                 (!bus.d_req_valid || starve_hit);
  end

  assign bus.d_req_ready  = d_grant;
  assign bus.if_req_ready = if_grant;

  // Transaction FSM with registered memory request fields, response pulses and status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= StIdle;
      starve_q          <= '0;
      drop_q            <= 1'b0;
      busy              <= 1'b0;
      owner             <= OwnIf;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we    <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_wdata <= '0;
      bus.mem_req_wstrb <= '0;
      bus.if_resp_valid <= 1'b0;
      bus.if_resp_data  <= '0;
      bus.d_resp_valid  <= 1'b0;
      bus.d_resp_data   <= '0;
    end else begin
      bus.if_resp_valid <= 1'b0;
      bus.d_resp_valid  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // Counter counts data grants that overtook a waiting fetch.
          if (d_grant && bus.if_req_valid) begin
            if (starve_q != CntMax) starve_q <= starve_q + CntW'(1);
          end else if (if_grant || !bus.if_req_valid) begin
            starve_q <= '0;
          end

          if (d_grant) begin
            state_q           <= StReq;
            busy              <= 1'b1;
            owner             <= OwnD;
            drop_q            <= 1'b0;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_we    <= bus.d_req_we;
            bus.mem_req_addr  <= bus.d_req_addr;
            bus.mem_req_wdata <= bus.d_req_wdata;
            bus.mem_req_wstrb <= bus.d_req_wstrb;
          end else if (if_grant) begin
            state_q           <= StReq;
            busy              <= 1'b1;
            owner             <= OwnIf;
            drop_q            <= 1'b0;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_we    <= 1'b0;
            bus.mem_req_addr  <= bus.if_req_addr;
            bus.mem_req_wdata <= '0;
            bus.mem_req_wstrb <= '0;
          end
        end

        StReq: begin
          if (flush && owner == OwnIf) drop_q <= 1'b1;
          if (bus.mem_req_ready) begin
            state_q           <= StWait;
            bus.mem_req_valid <= 1'b0;
          end
        end

        StWait: begin
          if (bus.mem_resp_valid) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            if (owner == OwnD) begin
              bus.d_resp_valid <= 1'b1;
              bus.d_resp_data  <= bus.mem_req_we ? '0 : bus.mem_resp_data;
            end else if (!(drop_q || flush)) begin
              // A flush in the response cycle itself also cancels delivery.
              bus.if_resp_valid <= 1'b1;
              bus.if_resp_data  <= bus.mem_resp_data;
            end
          end else if (flush && owner == OwnIf) begin
            drop_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: per-cycle input/expected-output records,
// plus a hand-written starvation sequence.
module tb_mem_arbiter;
  localparam logic [31:0] DAddr  = 32'h0000_0200;
  localparam logic [31:0] DWdata = 32'hDEAD_BEEF;
  localparam logic [3:0]  DWstrb = 4'hF;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  logic owner;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .busy (busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // flags: {if_req_ready, d_req_ready, mem_req_valid, mem_req_we, busy, owner,
  //         if_resp_valid, d_resp_valid}
  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        ifv;
    logic        dv;
    logic        dwe;
    logic        mrr;
    logic        mrv;
    logic [31:0] ia;
    logic [31:0] mrd;
    logic [7:0]  eflags;
    logic [31:0] eaddr;
    logic [31:0] eird;
    logic [31:0] edrd;
  } vec_t;

  localparam int NVec = 39;
  vec_t vecs [NVec];

  int applied = 0;
  int miscompares = 0;

  task automatic drive(input logic r, input logic fl, input logic ifv, input logic dv,
                       input logic dwe, input logic mrr, input logic mrv,
                       input logic [31:0] ia, input logic [31:0] mrd);
    rst                = r;
    flush              = fl;
    bus.if_req_valid   = ifv;
    bus.if_req_addr    = ia;
    bus.d_req_valid    = dv;
    bus.d_req_we       = dwe;
    bus.d_req_addr     = DAddr;
    bus.d_req_wdata    = DWdata;
    bus.d_req_wstrb    = DWstrb;
    bus.mem_req_ready  = mrr;
    bus.mem_resp_valid = mrv;
    bus.mem_resp_data  = mrd;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [7:0]  got_flags;
    logic [31:0] ewdata;
    logic [3:0]  ewstrb;
    got_flags = {bus.if_req_ready, bus.d_req_ready, bus.mem_req_valid, bus.mem_req_we,
                 busy, owner, bus.if_resp_valid, bus.d_resp_valid};
    // Data transactions latch the bench's constant store fields; fetch latches zeros.
    ewdata = v.eflags[2] ? DWdata : 32'h0;
    ewstrb = v.eflags[2] ? DWstrb : 4'h0;
    applied++;
    if (got_flags !== v.eflags || bus.mem_req_addr !== v.eaddr ||
        bus.mem_req_wdata !== ewdata || bus.mem_req_wstrb !== ewstrb ||
        bus.if_resp_data !== v.eird || bus.d_resp_data !== v.edrd) begin
      miscompares++;
      $display("FAIL vec%0d: got flags=%b addr=%h wd=%h ws=%h ird=%h drd=%h, want flags=%b addr=%h wd=%h ws=%h ird=%h drd=%h",
               idx, got_flags, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb,
               bus.if_resp_data, bus.d_resp_data, v.eflags, v.eaddr, ewdata, ewstrb,
               v.eird, v.edrd);
    end
  endtask

  initial begin
    //           rst fl ifv dv we mrr mrv ia             mrd            flags        addr           ird            drd
    // Reset, then fetch only
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0000,32'h0,  32'h0,  32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h100,   32'h0,     8'b1000_0000,32'h0,  32'h0,  32'h0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1000,32'h100,32'h0,  32'h0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'h13,    8'b0000_1000,32'h100,32'h0,  32'h0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0010,32'h100,32'h13, 32'h0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0000,32'h100,32'h13, 32'h0};
    // Priority: both valid, store wins
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h300,   32'h0,     8'b0100_0000,32'h100,32'h13, 32'h0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0011_1100,32'h200,32'h13, 32'h0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'h55,    8'b0001_1100,32'h200,32'h13, 32'h0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0001_0101,32'h200,32'h13, 32'h0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0001_0100,32'h200,32'h13, 32'h0};
    // Flush while waiting for the fetch response
    vecs[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h400,   32'h0,     8'b1001_0100,32'h200,32'h13, 32'h0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1000,32'h400,32'h13, 32'h0};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_1000,32'h400,32'h13, 32'h0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'hAAAA5555,8'b0000_1000,32'h400,32'h13,32'h0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0000,32'h400,32'h13, 32'h0};
    // Flush coincident with the response
    vecs[16] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h500,   32'h0,     8'b1000_0000,32'h400,32'h13, 32'h0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1000,32'h500,32'h13, 32'h0};
    vecs[18] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'hAAAA5555,8'b0000_1000,32'h500,32'h13,32'h0};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0000,32'h500,32'h13, 32'h0};
    // Normal fetch afterwards: drop must not linger
    vecs[20] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h600,   32'h0,     8'b1000_0000,32'h500,32'h13, 32'h0};
    vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1000,32'h600,32'h13, 32'h0};
    vecs[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'h1234,  8'b0000_1000,32'h600,32'h13, 32'h0};
    vecs[23] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0010,32'h600,32'h1234,32'h0};
    // Load in flight is immune to flush; flush in IDLE blocks fetch acceptance
    vecs[24] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0100_0000,32'h600,32'h1234,32'h0};
    vecs[25] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1100,32'h200,32'h1234,32'h0};
    vecs[26] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'hAAAA5555,8'b0000_1100,32'h200,32'h1234,32'h0};
    vecs[27] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h700,   32'h0,     8'b0000_0101,32'h200,32'h1234,32'hAAAA5555};
    vecs[28] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0100,32'h200,32'h1234,32'hAAAA5555};
    // Backpressure: 5 cycles without mem_req_ready, early mem_resp_valid ignored in REQ
    vecs[29] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h800,   32'h0,     8'b1000_0100,32'h200,32'h1234,32'hAAAA5555};
    vecs[30] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h900,   32'h0,     8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[31] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h900,   32'hBAD,   8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[32] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h900,   32'h0,     8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[33] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h900,   32'h0,     8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[34] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h900,   32'h0,     8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[35] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,     32'h0,     8'b0010_1000,32'h800,32'h1234,32'hAAAA5555};
    // Reset during WAIT, then a late response must be ignored
    vecs[36] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_1000,32'h800,32'h1234,32'hAAAA5555};
    vecs[37] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,     32'h0BAD,  8'b0000_0000,32'h0,  32'h0,  32'h0};
    vecs[38] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,     32'h0,     8'b0000_0000,32'h0,  32'h0,  32'h0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].ifv, vecs[i].dv, vecs[i].dwe,
            vecs[i].mrr, vecs[i].mrv, vecs[i].ia, vecs[i].mrd);
      #4;
      check_vec(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Starvation: both requesters held valid; expected grant order D D D D F D D D D F D.
    begin
      logic [10:0] fetch_turn;
      logic [1:0]  got;
      logic [1:0]  want;
      fetch_turn = 11'b000_0010_0001 << 4;
      for (int g = 0; g < 11; g++) begin
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC00 + 32'(g), 32'h0);
        #4;
        got  = {bus.if_req_ready, bus.d_req_ready};
        want = fetch_turn[g] ? 2'b10 : 2'b01;
        applied++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL starve_grant%0d: got {if_ready,d_ready}=%b, want %b", g, got, want);
        end
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC00 + 32'(g), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC00 + 32'(g), 32'h77);
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified memory between the instruction-fetch path and the data-memory path of the pipelined core, with at most one transaction in flight. Data requests have priority, and a starvation counter bounds how long fetch can be locked out. A pipeline flush cancels delivery of an in-flight fetch response. The block sits between the PC/IMEM fetch logic, the MEM-stage load/store logic and the external memory port.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes.
- `STARVE_MAX`, 4, number of consecutive data grants allowed while fetch waits; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  pipeline flush; cancels the pending/in-flight fetch.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  ADDR_W  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_resp_valid`  out  1  one-cycle pulse with the fetch data.
- `if_resp_data`  out  DATA_W  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_we`  in  1  1 = store, 0 = load.
- `d_req_addr`  in  ADDR_W  data address.
- `d_req_wdata`  in  DATA_W  store data.
- `d_req_wstrb`  in  DATA_W/8  store byte enables.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_resp_valid`  out  1  one-cycle pulse: load data or store acknowledge.
- `d_resp_data`  out  DATA_W  load data; 0 for stores.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
- `mem_resp_valid`  in  1  memory response or acknowledge; required for every request, including stores.
- `mem_resp_data`  in  DATA_W  memory read data.
- `busy`  out  1  high in REQ or WAIT.
- `owner`  out  1  0 = fetch, 1 = data; owner of the current or last transaction.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE.** Arbitrate combinationally:
  - Data wins, unless `if_req_valid && d_req_valid && starve_cnt == STARVE_MAX`, in which case fetch wins.
  - `if_req_ready` is forced to 0 while `flush` is high.
  - The winner's `*_req_ready` = 1. On acceptance, latch addr/we/wdata/wstrb (fetch: we=0, wstrb=0, wdata=0), set `owner`, clear `drop`, and go to REQ.
- **REQ.** `mem_req_valid` = 1 with the latched fields held stable. On `mem_req_ready`, go to WAIT. `mem_resp_valid` is ignored in REQ.
- **WAIT.** On `mem_resp_valid`, register the data into the owner's resp_data and pulse the owner's resp_valid the next cycle. Go to IDLE.
  - Fetch with `drop` set: the pulse is suppressed and the data discarded.
  - Store: `d_resp_data` = 0.
- **starve_cnt** (width clog2(STARVE_MAX+1)):
  - +1, saturating, on a data grant while `if_req_valid` = 1.
  - Cleared on a fetch grant, or in any IDLE cycle with `if_req_valid` = 0.
- **flush:** while `owner` = fetch and the state is REQ/WAIT, `flush` sets `drop`. Includes flush arriving in the same cycle as `mem_resp_valid`. Data transactions are never affected by flush.
- Only one transaction is outstanding; both `*_req_ready` are 0 outside IDLE.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - State IDLE; starve_cnt = 0; drop = 0.
  - All outputs 0, including resp data, mem_req fields, `busy` and `owner`.
- A memory response still in flight when reset is applied is ignored (IDLE ignores `mem_resp_valid`).
- Accept at cycle T → `mem_req_valid` at T+1. With `mem_req_ready` at T+1 → WAIT at T+2.
- `mem_resp_valid` at cycle R (R ≥ T+2) → resp_valid pulse at R+1. The FSM is IDLE at R+1, so a new accept is possible at R+1.
- Minimum request-to-response latency is 3 cycles; back-to-back accepts are 3 cycles apart.
- `mem_req_*` fields change only on acceptance; they are stable for the whole of REQ/WAIT.
- resp_valid is high for exactly 1 cycle, and resp_data is held until the next response for that owner.

## Test plan
- **Fetch only:** reset, then `if_req_valid` with addr 0x100; memory ready immediately and responds next cycle with 0x00000013 → `if_req_ready` at T, `mem_req_addr` = 0x100 at T+1, `if_resp_valid` with 0x00000013 at T+3, `d_resp_valid` stays 0.
- **Priority:** both valid in the same IDLE cycle with starve_cnt = 0 → `d_req_ready` = 1 and `if_req_ready` = 0; store of 0xDEADBEEF, wstrb 0xF, to 0x200 drives the `mem_req_*` fields exactly; ack gives `d_resp_valid` with data 0.
- **Starvation:** both held valid continuously, STARVE_MAX = 4 → grant order D, D, D, D, F, then D resumes; starve_cnt returns to 0 after the F grant.
- **Flush:** fetch accepted; flush asserted in WAIT; memory responds 0xAAAA5555 → no `if_resp_valid`, FSM returns to IDLE. Repeat with flush coincident with `mem_resp_valid` → same result. Repeat with a data load in flight → `d_resp_valid` still delivered.
- **Backpressure and reset:** `mem_req_ready` held low 5 cycles → fields stable, `busy` = 1, both ready outputs 0. Then `rst` = 0 during WAIT → next cycle all outputs 0 and state IDLE; a late `mem_resp_valid` produces no resp pulse.
